// File: rtl/apb_mem_sim.sv
// apb_mem_sim -- APB completer memory model for bridge testbenches.
//
// A word-organised memory behind an APB completer interface, with byte
// strobes, selectable wait-state behaviour, decode/alignment error
// responses and saturating transaction counters.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   apb_paddr         byte address (RAW bits)
//   apb_pprot         protection bits, accepted and ignored
//   apb_psel          select
//   apb_penable       access-phase enable
//   apb_pwrite        1 = write, 0 = read
//   apb_pwdata        write data (RW bits)
//   apb_pstrb         byte write strobes (RW/8 bits)
//   apb_pready        transfer completion, only high inside an access phase
//   apb_prdata        read data, holds the last completion value between transfers
//   apb_pslverr       error response, only high together with apb_pready
//   wait_mode         0 zero-wait, 1 fixed wait, 2 random wait, 3 stall
//   wait_cycles       wait states used in fixed-wait mode
//   wr_count          completed good writes (saturating)
//   rd_count          completed good reads (saturating)
//   err_count         completed error transfers (saturating)
module apb_mem_sim #(
  parameter int          RAW   = 32,
  parameter int          RW    = 32,
  parameter int          DEPTH = 512,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          CNTW  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RAW-1:0]  apb_paddr,
  input  logic [2:0]      apb_pprot,
  input  logic            apb_psel,
  input  logic            apb_penable,
  input  logic            apb_pwrite,
  input  logic [RW-1:0]   apb_pwdata,
  input  logic [RW/8-1:0] apb_pstrb,
  output logic            apb_pready,
  output logic [RW-1:0]   apb_prdata,
  output logic            apb_pslverr,
  input  logic [1:0]      wait_mode,
  input  logic [7:0]      wait_cycles,
  output logic [CNTW-1:0] wr_count,
  output logic [CNTW-1:0] rd_count,
  output logic [CNTW-1:0] err_count
);

  localparam int NB = RW / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state;
  state_t          state_nxt;

  // Transfer attributes captured at the setup phase
  logic [IW-1:0]   idx_q;
  logic            err_q;
  logic            write_q;
  logic [RW-1:0]   wdata_q;
  logic [NB-1:0]   strb_q;
  logic [1:0]      mode_q;
  logic [7:0]      wcnt_q;

  logic [15:0]     lfsr;
  logic [RW-1:0]   prdata_q;
  logic [RW-1:0]   mem [DEPTH];

  logic [RAW-1:0]  word_addr;
  logic            addr_err;
  logic            access_ph;
  logic            ready_cond;
  logic            done;
  logic            load_rdata;
  logic [RW-1:0]   rd_value;
  logic            lfsr_fb;
  logic            unused_pprot;

  assign unused_pprot = ^apb_pprot;

  // The full shifted address is compared against DEPTH so that addresses
  // above the memory never alias onto low words.
  assign word_addr = apb_paddr >> SH;
  assign addr_err  = (apb_paddr[SH-1:0] != '0) || (word_addr >= RAW'(DEPTH));

  assign access_ph = (state == ACCESS) && apb_psel && apb_penable;
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    state_nxt  = state;
    ready_cond = 1'b0;
    // Stall follows the live mode; other modes use what was captured at setup.
    if (wait_mode == 2'd3) begin
      ready_cond = 1'b0;
    end else if (mode_q == 2'd2) begin
      ready_cond = lfsr[0];
    end else begin
      ready_cond = (wcnt_q == 8'd0);
    end
    apb_pready = access_ph && ready_cond && !reset;
    case (state)
      IDLE: begin
        if (apb_psel && !apb_penable) state_nxt = ACCESS;
      end
      ACCESS: begin
        // Completion or a dropped psel/penable both end the transfer.
        if (!(apb_psel && apb_penable) || apb_pready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done       = apb_pready;
  assign load_rdata = done && (err_q || !write_q);

  always_comb begin
    rd_value = '0;
    if (!err_q) rd_value = mem[idx_q];
  end

  // Read data is presented combinationally on the completion cycle and
  // then held until the next read or error completion.
  assign apb_prdata  = load_rdata ? rd_value : prdata_q;
  assign apb_pslverr = done && err_q;

  // Control state: FSM, LFSR, held read data and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      prdata_q  <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      lfsr  <= {lfsr[14:0], lfsr_fb};
      if (load_rdata) prdata_q <= rd_value;
      if (done) begin
        if (err_q) begin
          if (err_count != '1) err_count <= err_count + CNTW'(1);
        end else if (write_q) begin
          if (wr_count != '1) wr_count <= wr_count + CNTW'(1);
        end else begin
          if (rd_count != '1) rd_count <= rd_count + CNTW'(1);
        end
      end
    end
  end

  // Setup-phase capture and wait counter
  always_ff @(posedge clk) begin
    if (state == IDLE && apb_psel && !apb_penable) begin
      idx_q   <= word_addr[IW-1:0];
      err_q   <= addr_err;
      write_q <= apb_pwrite;
      wdata_q <= apb_pwdata;
      strb_q  <= apb_pstrb;
      mode_q  <= wait_mode;
      wcnt_q  <= (wait_mode == 2'd1) ? wait_cycles : 8'd0;
    end else if (access_ph && wcnt_q != 8'd0) begin
      wcnt_q  <= wcnt_q - 8'd1;
    end
  end

  // Memory update on a good write completion
  always_ff @(posedge clk) begin
    if (done && write_q && !err_q) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_sim.sv
// tb_apb_mem_sim -- directed and scoreboarded checks for apb_mem_sim.
// Counters are built 8 bits wide so that saturation is reached during the
// random-wait phase.
module tb_apb_mem_sim;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [1:0]  wait_mode;
  logic [7:0]  wait_cycles;
  logic [7:0]  wr_count;
  logic [7:0]  rd_count;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_wr, exp_rd, exp_err;
  logic [31:0] sb [512];
  logic [3:0]  kn [512];

  always #5 clk = ~clk;

  apb_mem_sim #(.RAW(32), .RW(32), .DEPTH(512), .SEED(16'hACE1), .CNTW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .apb_paddr   (paddr),
    .apb_pprot   (pprot),
    .apb_psel    (psel),
    .apb_penable (penable),
    .apb_pwrite  (pwrite),
    .apb_pwdata  (pwdata),
    .apb_pstrb   (pstrb),
    .apb_pready  (pready),
    .apb_prdata  (prdata),
    .apb_pslverr (pslverr),
    .wait_mode   (wait_mode),
    .wait_cycles (wait_cycles),
    .wr_count    (wr_count),
    .rd_count    (rd_count),
    .err_count   (err_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_wr"},  64'(wr_count),  64'(exp_wr));
    check({tag, "_rd"},  64'(rd_count),  64'(exp_rd));
    check({tag, "_err"}, 64'(err_count), 64'(exp_err));
  endtask

  // Protocol handshake monitor
  always @(negedge clk) begin
    if (pready)  check("pready_phase", 64'(psel && penable), 64'd1);
    if (pslverr) check("slverr_gate", 64'(pready), 64'd1);
  end

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int cyc, output int waits);
    logic seen;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    cyc = 1; waits = 0; seen = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    while (!seen && waits <= 100) begin
      #1;
      cyc++;
      if (pready) begin
        seen = 1'b1;
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    rd  = prdata;
    err = pslverr;
    check("xfer_done", 64'(seen), 64'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st, input int exp_cyc);
    logic [31:0] rd, m;
    logic        err, e;
    int          cyc, waits;
    logic [8:0]  wi;
    e  = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd512);
    wi = addr[10:2];
    xfer(wr, addr, wd, st, rd, err, cyc, waits);
    check({tag, "_slverr"}, 64'(err), 64'(e));
    if (exp_cyc > 0) check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    if (e) begin
      check({tag, "_err_rdata"}, 64'(rd), 64'd0);
      exp_err = sat_inc(exp_err);
    end else if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) begin
          sb[wi][8*b +: 8] = wd[8*b +: 8];
          kn[wi][b] = 1'b1;
        end
      end
      exp_wr = sat_inc(exp_wr);
    end else begin
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{kn[wi][b]}};
      check({tag, "_rdata"}, 64'(rd & m), 64'(sb[wi] & m));
      exp_rd = sat_inc(exp_rd);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, wd;
    logic        err;
    int          cyc, waits, stall_seen;

    for (int i = 0; i < 512; i++) begin
      sb[i] = '0;
      kn[i] = '0;
    end
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b010;
    wait_mode = 2'd0; wait_cycles = 8'd0;
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready",  64'(pready),  64'd0);
    check("rst_prdata",  64'(prdata),  64'd0);
    check("rst_pslverr", 64'(pslverr), 64'd0);
    check_counts("rst");
    reset = 1'b0;

    // Zero-wait write/read
    do_op("m0_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2);
    do_op("m0_rd", 1'b0, 32'h10, 32'h0, 4'h0, 2);
    check("m0_rd_value", 64'(prdata), 64'hDEADBEEF);
    check_counts("m0");

    // Byte strobes
    do_op("st_wr1", 1'b1, 32'h20, 32'h11223344, 4'hF, 2);
    do_op("st_wr2", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2);
    do_op("st_rd",  1'b0, 32'h20, 32'h0, 4'h0, 2);
    check("st_value", 64'(prdata), 64'h11BB33DD);
    do_op("st_wr0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 2);
    do_op("st_rd0", 1'b0, 32'h20, 32'h0, 4'h0, 2);
    check("st0_value", 64'(prdata), 64'h11BB33DD);
    check_counts("st");

    // Fixed wait states
    wait_mode = 2'd1; wait_cycles = 8'd3;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, err, cyc, waits);
    check("m1_waits",  64'(waits), 64'd3);
    check("m1_cycles", 64'(cyc),   64'd5);
    check("m1_rdata",  64'(rd),    64'hDEADBEEF);
    check("m1_slverr", 64'(err),   64'd0);
    exp_rd = sat_inc(exp_rd);
    wait_mode = 2'd0;

    // Decode errors
    do_op("lw_wr",   1'b1, 32'h7FC, 32'h12345678, 4'hF, 2);
    do_op("ua_rd",   1'b0, 32'h802, 32'h0, 4'h0, 2);
    do_op("oob_wr",  1'b1, 32'h800, 32'hCAFEF00D, 4'hF, 2);
    check_counts("err");
    do_op("lw_rd",   1'b0, 32'h7FC, 32'h0, 4'h0, 2);
    check("lw_value", 64'(prdata), 64'h12345678);
    @(posedge clk); #1;
    check("prdata_hold", 64'(prdata), 64'h12345678);
    do_op("alias_rd", 1'b0, 32'h1000_0010, 32'h0, 4'h0, 2);
    check("alias_prdata", 64'(prdata), 64'd0);
    check_counts("err2");

    // Aborted transfer leaves memory and counters alone
    wait_mode = 2'd1; wait_cycles = 8'd5;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
    wait_mode = 2'd0;
    do_op("abort_rd", 1'b0, 32'h10, 32'h0, 4'h0, 2);
    check("abort_value", 64'(prdata), 64'hDEADBEEF);
    check_counts("abort");

    // Random wait states against the scoreboard
    wait_mode = 2'd2;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(15) == 0) begin
        if ($urandom_range(1) == 1) a = 32'h800 + (32'($urandom_range(63)) << 2);
        else a = (32'($urandom_range(31)) << 2) | 32'($urandom_range(3, 1));
      end else begin
        a = 32'($urandom_range(31)) << 2;
      end
      wd = $urandom;
      do_op("m2", 1'($urandom_range(1)), a, wd, 4'($urandom_range(15)), 0);
    end
    check_counts("m2");

    // Stall, then reset in the middle of the access
    wait_mode = 2'd3;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    stall_seen = 0;
    repeat (6) begin
      #1;
      if (pready) stall_seen++;
      @(posedge clk); #1;
    end
    check("m3_stall", 64'(stall_seen), 64'd0);
    reset = 1'b1;
    #1;
    check("rst_mid_pready", 64'(pready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_mode = 2'd0;
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    #1;
    check("post_rst_idle", 64'(pready), 64'd0);
    check("post_rst_prdata", 64'(prdata), 64'd0);
    check_counts("post_rst");
    psel = 1'b0; penable = 1'b0;
    do_op("post_wr", 1'b1, 32'h30, 32'h5A5AA5A5, 4'hF, 2);
    do_op("post_rd", 1'b0, 32'h30, 32'h0, 4'h0, 2);
    check("post_value", 64'(prdata), 64'h5A5AA5A5);
    check_counts("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
